// File: rtl/pkt_reasm.sv
// pkt_reasm: receive-side packet reassembler (NoC local port -> AXI RX buffer).
// Tracks framing per virtual channel using the head-flit size field, strips
// the flit-type bits and tags beats with sof/eof/err.
// Optional: PKT_REASM_ERR_CNT_EN enables the saturating framing-error counter;
// when undefined err_cnt_o is tied to zero.
module pkt_reasm #(
  parameter int FlitWidth     = 34,
  parameter int FlitDataWidth = 32,
  parameter int NumVirtChn    = 3,
  parameter int PktWidth      = 8,
  parameter int PktSzLsb      = 0,
  localparam int VcWidth      = (NumVirtChn > 1) ? $clog2(NumVirtChn) : 1
) (
  input  logic                     clk_axi,
  input  logic                     arst_axi_n,
  input  logic                     flit_valid_i,
  output logic                     flit_ready_o,
  input  logic [FlitWidth-1:0]     flit_data_i,
  input  logic [VcWidth-1:0]       flit_vc_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [FlitDataWidth-1:0] out_data_o,
  output logic [VcWidth-1:0]       out_vc_o,
  output logic                     out_sof_o,
  output logic                     out_eof_o,
  output logic                     out_err_o,
  output logic [NumVirtChn-1:0]    vc_busy_o,
  output logic [15:0]              err_cnt_o
);

  typedef enum logic [1:0] {HEAD = 2'b00, BODY = 2'b01, TAIL = 2'b10, RSVD = 2'b11} ftype_t;
  typedef enum logic {IDLE = 1'b0, PAYLOAD = 1'b1} vc_st_t;

  vc_st_t              r_state [NumVirtChn];
  logic [PktWidth-1:0] r_cnt   [NumVirtChn];
  vc_st_t              w_state_nxt [NumVirtChn];
  logic [PktWidth-1:0] w_cnt_nxt   [NumVirtChn];

  logic                     r_valid, r_sof, r_eof, r_err;
  logic [FlitDataWidth-1:0] r_data;
  logic [VcWidth-1:0]       r_vc;

  logic                w_acc, w_vc_ok, w_fwd, w_sof, w_eof, w_err, w_err_evt;
  logic [VcWidth-1:0]  w_vc_idx;
  logic [PktWidth-1:0] w_sz;
  ftype_t              w_type;

  // Single output register: a new flit may enter whenever the slot is free or drains now.
  assign flit_ready_o = ~r_valid | out_ready_i;
  assign w_acc        = flit_valid_i & flit_ready_o;
  assign w_type       = ftype_t'(flit_data_i[FlitWidth-1 -: 2]);
  assign w_sz         = flit_data_i[PktSzLsb +: PktWidth];
  assign w_vc_ok      = int'(flit_vc_i) < NumVirtChn;
  assign w_vc_idx     = w_vc_ok ? flit_vc_i : '0;

  // Per-VC next state and beat framing for the accepted flit.
  always_comb begin
    for (int v = 0; v < NumVirtChn; v++) begin
      w_state_nxt[v] = r_state[v];
      w_cnt_nxt[v]   = r_cnt[v];
    end
    w_fwd = 1'b0; w_sof = 1'b0; w_eof = 1'b0; w_err = 1'b0; w_err_evt = 1'b0;
    if (w_acc) begin
      if (!w_vc_ok || w_type == RSVD) begin
        w_err_evt = 1'b1;
      end else if (w_type == HEAD) begin
        // A head in PAYLOAD aborts the previous packet but still starts a new one.
        w_fwd = 1'b1;
        w_sof = 1'b1;
        w_err = (r_state[w_vc_idx] == PAYLOAD);
        w_err_evt = w_err;
        if (w_sz == '0) begin
          w_eof = 1'b1;
          w_state_nxt[w_vc_idx] = IDLE;
        end else begin
          w_state_nxt[w_vc_idx] = PAYLOAD;
          w_cnt_nxt[w_vc_idx]   = w_sz - 1'b1;
        end
      end else if (r_state[w_vc_idx] == IDLE) begin
        w_err_evt = 1'b1;   // orphan body/tail: swallowed
      end else if (w_type == BODY) begin
        w_fwd = 1'b1;
        if (r_cnt[w_vc_idx] == '0) begin
          w_eof = 1'b1; w_err = 1'b1; w_err_evt = 1'b1;
          w_state_nxt[w_vc_idx] = IDLE;
        end else begin
          w_cnt_nxt[w_vc_idx] = r_cnt[w_vc_idx] - 1'b1;
        end
      end else begin
        w_fwd = 1'b1;
        w_eof = 1'b1;
        w_err = (r_cnt[w_vc_idx] != '0);
        w_err_evt = w_err;
        w_state_nxt[w_vc_idx] = IDLE;
      end
    end
  end

  // Per-VC state registers.
  always_ff @(posedge clk_axi or negedge arst_axi_n) begin
    if (!arst_axi_n) begin
      for (int v = 0; v < NumVirtChn; v++) begin
        r_state[v] <= IDLE;
        r_cnt[v]   <= '0;
      end
    end else begin
      for (int v = 0; v < NumVirtChn; v++) begin
        r_state[v] <= w_state_nxt[v];
        r_cnt[v]   <= w_cnt_nxt[v];
      end
    end
  end

  // Output register: reload on accept, fields hold while stalled.
  always_ff @(posedge clk_axi or negedge arst_axi_n) begin
    if (!arst_axi_n) begin
      r_valid <= 1'b0; r_data <= '0; r_vc <= '0;
      r_sof <= 1'b0; r_eof <= 1'b0; r_err <= 1'b0;
    end else if (flit_ready_o) begin
      r_valid <= w_fwd;
      if (w_fwd) begin
        r_data <= flit_data_i[FlitDataWidth-1:0];
        r_vc   <= flit_vc_i;
        r_sof  <= w_sof;
        r_eof  <= w_eof;
        r_err  <= w_err;
      end
    end
  end

  assign out_valid_o = r_valid;
  assign out_data_o  = r_data;
  assign out_vc_o    = r_vc;
  assign out_sof_o   = r_sof;
  assign out_eof_o   = r_eof;
  assign out_err_o   = r_err;

  // Busy flag per VC mirrors the PAYLOAD state.
  always_comb begin
    vc_busy_o = '0;
    for (int v = 0; v < NumVirtChn; v++) vc_busy_o[v] = (r_state[v] == PAYLOAD);
  end

`ifdef PKT_REASM_ERR_CNT_EN
  logic [15:0] r_err_cnt;

  // Saturating framing-error counter.
  always_ff @(posedge clk_axi or negedge arst_axi_n) begin
    if (!arst_axi_n)                            r_err_cnt <= '0;
    else if (w_err_evt && r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
  end

  assign err_cnt_o = r_err_cnt;
`else
  logic w_unused_err_evt;
  assign w_unused_err_evt = w_err_evt;
  assign err_cnt_o        = '0;
`endif

endmodule
